// File: rtl/sram_word_controller_pkg.sv
// Shared constants, state encodings and request payload for the 32-bit-over-16-bit SRAM word controller.
package sram_word_controller_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WORD_IDX_W  = SRAM_ADDR_W - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic                  write;
    logic [WORD_IDX_W-1:0] word;
    logic [WORD_W-1:0]     wdata;
  } req_t;

  // Byte address to SRAM word index; wraps modulo the SRAM word count.
  function automatic logic [WORD_IDX_W-1:0] word_index(input logic [WORD_W-1:0] address,
                                                        input logic [WORD_W-1:0] base);
    return WORD_IDX_W'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_word_controller_if.sv
// MEM-stage word request bus between the pipeline (master) and the SRAM controller (slave).
interface sram_word_controller_if;
  import sram_word_controller_pkg::*;

  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] read_data;
  logic              ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);

endinterface

// File: rtl/sram_word_controller.sv
// Serves 32-bit pipeline loads/stores as two 16-bit accesses to the DE2 async SRAM; stalls via ready.
module sram_word_controller
  import sram_word_controller_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE     = 32'd1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_word_controller_if.slave  bus,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int unsigned     CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  logic [1:0]             state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  req_t                   req, req_n;
  logic [WORD_W-1:0]      rdata, rdata_n;
  logic [SRAM_ADDR_W-1:0] sram_addr_n;
  logic                   we_n_n;
  logic                   dq_oe, dq_oe_n;
  logic [SRAM_DATA_W-1:0] dq_out, dq_out_n;
  logic                   active_n;
  logic                   high_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req       <= '0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req       <= req_n;
      rdata     <= rdata_n;
      SRAM_ADDR <= sram_addr_n;
      SRAM_WE_N <= we_n_n;
      dq_oe     <= dq_oe_n;
      dq_out    <= dq_out_n;
    end
  end

  // SRAM pins are registered from the next state, so they are stable for each whole half-access.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    rdata_n = rdata;

    unique case (state)
      S_IDLE: begin
        if (bus.wr_en || bus.rd_en) begin
          req_n.write = bus.wr_en;
          req_n.word  = word_index(bus.address, ADDR_BASE);
          req_n.wdata = bus.write_data;
          cnt_n       = '0;
          state_n     = S_LOW;
        end
      end
      S_LOW, S_HIGH: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = (state == S_LOW) ? S_HIGH : S_DONE;
          if (!req.write) begin
            if (state == S_LOW) rdata_n[15:0]  = SRAM_DQ;
            else                rdata_n[31:16] = SRAM_DQ;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // WE_N releases on the last cycle of each half so the address is still held at its rising edge.
    active_n    = (state_n == S_LOW) || (state_n == S_HIGH);
    high_n      = (state_n == S_HIGH);
    sram_addr_n = active_n ? {req_n.word, high_n} : SRAM_ADDR;
    we_n_n      = !(active_n && req_n.write && (cnt_n != CNT_LAST));
    dq_oe_n     = active_n && req_n.write;
    dq_out_n    = high_n ? req_n.wdata[31:16] : req_n.wdata[15:0];
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign bus.read_data = rdata;
  assign bus.ready     = ((state == S_IDLE) && !bus.wr_en && !bus.rd_en) || (state == S_DONE);

endmodule

// File: tb/tb_sram_word_controller.sv
// Scoreboard bench: two controllers (2-cycle and 1-cycle halves) against behavioural async SRAMs.
module tb_sram_word_controller;
  import sram_word_controller_pkg::*;

  localparam int unsigned AC0    = 2;
  localparam int unsigned AC1    = 1;
  localparam logic [31:0] BASE   = 32'd1024;
  localparam int unsigned NWORDS = 131072;
  localparam int unsigned NHALF  = 262144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        wr_v    [2];
  logic        rd_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];
  logic        ready_v [2];

  sram_word_controller_if bus0 ();
  sram_word_controller_if bus1 ();

  assign bus0.wr_en      = wr_v[0];
  assign bus0.rd_en      = rd_v[0];
  assign bus0.address    = addr_v[0];
  assign bus0.write_data = wdata_v[0];
  assign rdata_v[0]      = bus0.read_data;
  assign ready_v[0]      = bus0.ready;
  assign bus1.wr_en      = wr_v[1];
  assign bus1.rd_en      = rd_v[1];
  assign bus1.address    = addr_v[1];
  assign bus1.write_data = wdata_v[1];
  assign rdata_v[1]      = bus1.read_data;
  assign ready_v[1]      = bus1.ready;

  wire  [15:0] dq0, dq1;
  logic [17:0] sa0, sa1;
  logic        we0, ub0, lb0, ce0, oe0;
  logic        we1, ub1, lb1, ce1, oe1;

  sram_word_controller #(.ADDR_BASE(BASE), .ACCESS_CYCLES(AC0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .bus(bus0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0));

  sram_word_controller #(.ADDR_BASE(BASE), .ACCESS_CYCLES(AC1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .bus(bus1),
    .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1));

  // Async SRAM models: latch on WE_N rising if address and data held; outputs off just after a write strobe.
  logic [15:0] mem0 [NHALF];
  logic [15:0] mem1 [NHALF];
  logic [31:0] ref1 [NWORDS];
  logic        we0_q = 1'b1, we1_q = 1'b1;
  logic [17:0] pa0 = '0, pa1 = '0;
  logic [15:0] pd0 = '0, pd1 = '0;
  logic        do_load = 1'b0;

  assign dq0 = (we0 && we0_q && !ce0 && !oe0) ? mem0[sa0] : 16'bz;
  assign dq1 = (we1 && we1_q && !ce1 && !oe1) ? mem1[sa1] : 16'bz;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < NWORDS; i++) begin
        logic [31:0] r;
        r = $urandom;
        mem0[2*i]   <= 16'h0;
        mem0[2*i+1] <= 16'h0;
        mem1[2*i]   <= r[15:0];
        mem1[2*i+1] <= r[31:16];
        ref1[i]     <= r;
      end
    end else begin
      if (!we0) begin
        pa0 <= sa0;
        pd0 <= dq0;
      end else if (!we0_q && sa0 == pa0 && dq0 == pd0) begin
        mem0[pa0] <= dq0;
      end
      if (!we1) begin
        pa1 <= sa1;
        pd1 <= dq1;
      end else if (!we1_q && sa1 == pa1 && dq1 == pd1) begin
        mem1[pa1] <= dq1;
      end
    end
    we0_q <= we0;
    we1_q <= we1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          busy;
  } exp_t;
  exp_t exp_q [$];

  logic [31:0] ref0    [NWORDS];
  logic [31:0] last_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % NWORDS;
  endfunction

  // Issue one word request, hold it until ready, and queue what the monitor should see.
  task automatic do_req(input int p, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d);
    int unsigned w;
    exp_t        e;
    bit          done;
    w = word_of(a);
    if (wr) begin
      if (p == 0) ref0[w] = d;
      e.rdata = last_rd[p];
    end else begin
      e.rdata    = (p == 0) ? ref0[w] : ref1[w];
      last_rd[p] = e.rdata;
    end
    e.port = p;
    e.busy = 2 * int'((p == 0) ? AC0 : AC1);
    exp_q.push_back(e);

    @(negedge clk);
    wr_v[p] = wr; rd_v[p] = rd; addr_v[p] = a; wdata_v[p] = d;
    #1 check($sformatf("p%0d ready_low_on_request", p), 32'(ready_v[p]), 32'd0);
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (n == 0) begin
        addr_v[p]  = $urandom;
        wdata_v[p] = $urandom;
      end
      if (ready_v[p]) done = 1'b1;
    end
    wr_v[p] = 1'b0; rd_v[p] = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL p%0d ready_timeout: ready stayed 0 for 40 cycles, required 1", p);
    end
  endtask

  // Monitor: a 0->1 ready transition outside reset marks a completed transfer.
  int busy [2] = '{0, 0};
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 2; p++) begin
      if (!rst_v[p]) begin
        busy[p] = 0;
      end else if (!ready_v[p]) begin
        busy[p]++;
      end else if (busy[p] != 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL p%0d unexpected_completion: got completion, required none", p);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("p%0d completion_port", p), 32'(p), 32'(e.port));
          check($sformatf("p%0d read_data", p), rdata_v[p], e.rdata);
          check($sformatf("p%0d busy_cycles", p), 32'(busy[p]), 32'(e.busy));
        end
        busy[p] = 0;
      end
    end
  end

  function automatic logic [31:0] rand_addr(input int unsigned span);
    if ($urandom_range(0, 7) == 0) return BASE - 32'(4 * $urandom_range(1, 4));
    return BASE + 32'(4 * $urandom_range(0, span - 1)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int p = 0; p < 2; p++) begin
      rst_v[p] = 1'b0; wr_v[p] = 1'b0; rd_v[p] = 1'b0;
      addr_v[p] = '0; wdata_v[p] = '0; last_rd[p] = '0;
    end
    for (int i = 0; i < NWORDS; i++) ref0[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("p0 reset_ready", 32'(ready_v[0]), 32'd1);
    check("p0 reset_we_n", 32'(we0), 32'd1);
    check("p0 reset_read_data", rdata_v[0], 32'd0);
    check("p0 reset_sram_addr", 32'(sa0), 32'd0);
    check("p0 tie_offs", 32'({ub0, lb0, ce0, oe0}), 32'd0);
    check("p1 reset_ready", 32'(ready_v[1]), 32'd1);
    check("p1 reset_read_data", rdata_v[1], 32'd0);
    check("p1 tie_offs", 32'({ub1, lb1, ce1, oe1}), 32'd0);
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
    repeat (2) @(negedge clk);

    // Write then read back, word 0
    do_req(0, 1'b1, 1'b0, BASE, 32'hDEADBEEF);
    check("p0 mem0_low", 32'(mem0[0]), 32'h0000BEEF);
    check("p0 mem1_high", 32'(mem0[1]), 32'h0000DEAD);
    do_req(0, 1'b0, 1'b1, BASE, 32'h0);

    // Next word lands at SRAM halves 2/3, word 0 untouched
    do_req(0, 1'b1, 1'b0, BASE + 32'd4, 32'h12345678);
    check("p0 mem2", 32'(mem0[2]), 32'h00005678);
    check("p0 mem3", 32'(mem0[3]), 32'h00001234);
    check("p0 mem0_kept", 32'(mem0[0]), 32'h0000BEEF);
    check("p0 mem1_kept", 32'(mem0[1]), 32'h0000DEAD);

    // Write wins over read; read_data keeps the last load value
    do_req(0, 1'b1, 1'b1, BASE + 32'd8, 32'hA5A55A5A);
    check("p0 mem4", 32'(mem0[4]), 32'h00005A5A);
    check("p0 mem5", 32'(mem0[5]), 32'h0000A5A5);
    check("p0 read_data_after_write", rdata_v[0], 32'hDEADBEEF);

    // Reset during the high half of a write: low half stays written, high half aborted
    @(negedge clk);
    wr_v[0] = 1'b1; addr_v[0] = BASE; wdata_v[0] = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0; wr_v[0] = 1'b0;
    @(negedge clk);
    check("p0 abort_ready", 32'(ready_v[0]), 32'd1);
    check("p0 abort_we_n", 32'(we0), 32'd1);
    check("p0 abort_read_data", rdata_v[0], 32'd0);
    rst_v[0] = 1'b1;
    @(negedge clk);
    check("p0 abort_mem0", 32'(mem0[0]), 32'h0000F00D);
    check("p0 abort_mem1", 32'(mem0[1]), 32'h0000DEAD);
    ref0[0][15:0] = 16'hF00D;
    last_rd[0]    = '0;
    do_req(0, 1'b0, 1'b1, BASE, 32'h0);

    // Random mixed traffic including wrapped addresses below the base
    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      do_req(0, r < 4, (r >= 4) || (r == 0), rand_addr(16), $urandom);
    end
    for (int w = 0; w < 16; w++)
      check($sformatf("p0 final_word%0d", w), {mem0[2*w+1], mem0[2*w]}, ref0[w]);
    for (int w = NWORDS - 4; w < NWORDS; w++)
      check($sformatf("p0 final_word%0d", w), {mem0[2*w+1], mem0[2*w]}, ref0[w]);

    // Single-cycle halves: reads only, back to back
    do_req(1, 1'b0, 1'b1, BASE + 32'd20, 32'h0);
    for (int i = 0; i < 20; i++) do_req(1, 1'b0, 1'b1, rand_addr(64), $urandom);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
